// File: rtl/dcache_miss_ctrl.sv
// Miss engine for the write-back dCache: dirty-victim writeback burst, then a
// critical-word-first wrapping refill with early restart and r_last checking.
module dcache_miss_ctrl #(
  parameter  int LINE_WORDS = 8,
  parameter  int ADDR_W     = 32,
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [31:0]       victim_rdata,
  output logic [OFF_W-1:0]  vic_idx,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [31:0]       w_data,
  output logic              w_last,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [31:0]       r_data,
  input  logic              r_last,
  output logic              fill_we,
  output logic [OFF_W-1:0]  fill_idx,
  output logic [31:0]       fill_data,
  output logic              crit_valid,
  output logic [31:0]       crit_data,
  output logic              done,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [2:0] {IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE} state_e;

  typedef struct packed {
    logic [ADDR_W-3:0] maddr;   // word address of the miss
    logic [ADDR_W-1:0] vaddr;
    logic [OFF_W-1:0]  crit;
  } ctx_t;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  ctx_t               ctx_q, ctx_d;
  logic               perr_q, perr_d;
  logic               last_beat;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[1:0];
  assign last_beat        = (cnt_q == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctx_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: if (miss_req) begin
        ctx_d.maddr = miss_addr[ADDR_W-1:2];
        ctx_d.vaddr = victim_addr;
        ctx_d.crit  = miss_addr[OFF_W+1:2];
        state_d     = victim_dirty ? WB_AW : RD_AR;
      end
      WB_AW: if (aw_ready) begin
        cnt_d   = '0;
        state_d = WB_W;
      end
      WB_W: if (w_ready) begin
        cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = WB_B;
      end
      // refill waits for the writeback response so memory never sees stale data
      WB_B: if (b_valid) state_d = RD_AR;
      RD_AR: if (ar_ready) begin
        cnt_d   = '0;
        state_d = RD_R;
      end
      RD_R: if (r_valid) begin
        cnt_d = cnt_q + 1'b1;
        // the beat count, not r_last, decides completion
        if (r_last != last_beat) perr_d = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign aw_addr   = ctx_q.vaddr;
  assign ar_addr   = {ctx_q.maddr, 2'b00};
  assign busy      = (state_q != IDLE);
  assign proto_err = perr_q;

  always_comb begin
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_data     = '0;
    vic_idx    = '0;
    b_ready    = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    fill_we    = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    crit_valid = 1'b0;
    crit_data  = '0;
    done       = 1'b0;
    case (state_q)
      WB_AW: aw_valid = 1'b1;
      WB_W: begin
        w_valid = 1'b1;
        vic_idx = cnt_q;
        w_data  = victim_rdata;
        w_last  = last_beat;
      end
      WB_B:  b_ready  = 1'b1;
      RD_AR: ar_valid = 1'b1;
      RD_R: begin
        r_ready  = 1'b1;
        fill_idx = ctx_q.crit + cnt_q;
        if (r_valid) begin
          fill_we   = 1'b1;
          fill_data = r_data;
          if (cnt_q == '0) begin
            crit_valid = 1'b1;
            crit_data  = r_data;
          end
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed/random bench for dcache_miss_ctrl acting as memory and line array,
// with queued expectations for writeback words and refill indices.
module tb_dcache_miss_ctrl;
  localparam int LW = 8;
  localparam int AW = 32;
  localparam int OW = 3;

  logic          clk, resetn;
  logic          miss_req, victim_dirty;
  logic [AW-1:0] miss_addr, victim_addr;
  logic [31:0]   victim_rdata;
  logic [OW-1:0] vic_idx, fill_idx;
  logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [31:0]   w_data, r_data, fill_data, crit_data;
  logic          fill_we, crit_valid, done, busy, proto_err;

  dcache_miss_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_rdata(victim_rdata),
    .vic_idx(vic_idx), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_last(r_last), .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .crit_valid(crit_valid), .crit_data(crit_data), .done(done), .busy(busy),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] line_mem [LW];
  assign victim_rdata = line_mem[vic_idx];

  int npass = 0;
  int ntot  = 0;
  logic [31:0]   wq [$];
  logic [OW-1:0] rq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic go(input int stall);
    return int'($urandom_range(99)) >= stall;
  endfunction

  task automatic idle_inputs();
    miss_req = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_last = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);        chk({tag, "_aw_valid"}, aw_valid, 0);
    chk({tag, "_w_valid"}, w_valid, 0);  chk({tag, "_w_last"}, w_last, 0);
    chk({tag, "_w_data"}, w_data, 0);    chk({tag, "_vic_idx"}, vic_idx, 0);
    chk({tag, "_b_ready"}, b_ready, 0);  chk({tag, "_ar_valid"}, ar_valid, 0);
    chk({tag, "_r_ready"}, r_ready, 0);  chk({tag, "_fill_we"}, fill_we, 0);
    chk({tag, "_crit_valid"}, crit_valid, 0); chk({tag, "_done"}, done, 0);
    chk({tag, "_aw_addr"}, aw_addr, 0);  chk({tag, "_ar_addr"}, ar_addr, 0);
    chk({tag, "_fill_idx"}, fill_idx, 0); chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  // One miss from request to the IDLE cycle after done; phases mirror the
  // expected bus order: 0 AW, 1 W, 2 B, 3 AR, 4 R, 5 DONE.
  task automatic do_miss(input logic [31:0] maddr, input logic dirty, input logic [31:0] vaddr,
                         input int stall, input int bad_beat, input int abort_beat,
                         input int exp_lat, input bit hold_req);
    int ph, wk, rk, cyc;
    logic [OW-1:0] crit;
    logic [31:0]   wexp;
    crit = maddr[OW+1:2];
    if (dirty)
      for (int k = 0; k < LW; k++) begin
        line_mem[k] = $urandom;
        wq.push_back(line_mem[k]);
      end
    for (int k = 0; k < LW; k++) rq.push_back(OW'(int'(crit) + k));
    @(negedge clk);
    miss_req = 1; miss_addr = maddr; victim_dirty = dirty; victim_addr = vaddr;
    #1 chk("idle_busy", busy, 0);
    ph = dirty ? 0 : 3; wk = 0; rk = 0; cyc = 0;
    while (ph != 6) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 1, 0);
        break;
      end
      if (hold_req) begin
        miss_addr = $urandom; victim_addr = $urandom; victim_dirty = 1'($urandom);
      end else miss_req = 0;
      aw_ready = go(stall); w_ready = go(stall); b_valid = go(stall);
      ar_ready = go(stall); r_valid = go(stall); r_data = $urandom;
      r_last   = (rk == LW - 1) || (rk == bad_beat);
      #1;
      case (ph)
        0: begin
          chk("aw_valid", aw_valid, 1); chk("aw_addr", aw_addr, vaddr);
          chk("ar_held_aw", ar_valid, 0);
          if (aw_ready) ph = 1;
        end
        1: begin
          if (wk == abort_beat) begin
            resetn = 0;
            #1 chk_all_zero("rst_abort");
            wq.delete(); rq.delete();
            @(negedge clk); idle_inputs();
            @(negedge clk); resetn = 1;
            return;
          end
          chk("w_valid", w_valid, 1); chk("vic_idx", vic_idx, wk);
          chk("ar_held_w", ar_valid, 0);
          if (w_ready) begin
            wexp = wq.pop_front();
            chk("w_data", w_data, wexp);
            chk("w_last", w_last, wk == LW - 1);
            wk++;
            if (wk == LW) ph = 2;
          end
        end
        2: begin
          chk("b_ready", b_ready, 1); chk("ar_held_b", ar_valid, 0);
          if (b_valid) ph = 3;
        end
        3: begin
          chk("ar_valid", ar_valid, 1); chk("ar_addr", ar_addr, {maddr[31:2], 2'b00});
          if (ar_ready) ph = 4;
        end
        4: begin
          chk("r_ready", r_ready, 1); chk("fill_we", fill_we, r_valid);
          chk("no_reissue", ar_valid | aw_valid, 0); chk("done_early", done, 0);
          if (r_valid) begin
            chk("fill_idx", fill_idx, rq.pop_front());
            chk("fill_data", fill_data, r_data);
            chk("crit_valid", crit_valid, rk == 0);
            if (rk == 0) chk("crit_data", crit_data, r_data);
            rk++;
            if (rk == LW) ph = 5;
          end else chk("crit_idle", crit_valid, 0);
        end
        default: begin
          chk("done", done, 1); chk("done_busy", busy, 1);
          chk("done_r_ready", r_ready, 0); chk("done_no_ar", ar_valid, 0);
          if (exp_lat >= 0) chk("latency", cyc, exp_lat);
          ph = 6;
        end
      endcase
    end
    @(negedge clk);
    idle_inputs();
    #1 chk("done_pulse", done, 0); chk("back_idle", busy, 0);
  endtask

  initial begin
    resetn = 0; miss_addr = '0; victim_addr = '0; victim_dirty = 0;
    idle_inputs();
    for (int k = 0; k < LW; k++) line_mem[k] = '0;
    #3 chk_all_zero("reset");
    @(negedge clk); @(negedge clk); resetn = 1;

    do_miss(32'h1014, 0, 32'h0, 0, -1, -1, LW + 2, 0);
    chk("clean_perr", proto_err, 0);
    do_miss(32'h3008, 1, 32'h2000, 40, -1, -1, -1, 0);
    do_miss(32'h401C, 1, 32'h2000, 0, -1, -1, 2 * LW + 4, 0);
    for (int i = 0; i < 4; i++)
      do_miss($urandom, 1'($urandom), $urandom & 32'hFFFF_FFE0, 50, -1, -1, -1, 0);
    chk("rand_perr", proto_err, 0);

    do_miss(32'h5004, 0, 32'h0, 20, 3, -1, -1, 0);
    chk("perr_set", proto_err, 1);
    do_miss(32'h6010, 0, 32'h0, 0, -1, -1, LW + 2, 0);
    chk("perr_sticky", proto_err, 1);

    do_miss(32'h7000, 1, 32'h2000, 0, -1, 4, -1, 0);
    chk("perr_cleared", proto_err, 0);
    do_miss(32'h7018, 1, 32'h8000, 30, -1, -1, -1, 0);
    chk("post_rst_perr", proto_err, 0);

    do_miss(32'h900C, 1, 32'hA000, 25, -1, -1, -1, 1);
    chk("hold_perr", proto_err, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Parametrised miss-handling engine for the write-back data cache. It sits between the dCache lookup/line-array logic and the AXI-style memory port. On a miss it writes back the dirty victim line as an incrementing burst, then refills the line with a critical-word-first wrapping burst. It provides early restart, so the CPU gets the missing word before the line completes, and it reports protocol errors.

## Interface
Parameters:
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..64
- ADDR_W, 32, byte-address width
- OFF_W, $clog2(LINE_WORDS), derived word-offset width; not overridable

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- miss_req  in  1  lookup missed; sampled only in IDLE
- miss_addr  in  ADDR_W  byte address of the missing access; bits [1:0] ignored
- victim_dirty  in  1  selected victim line is valid and dirty
- victim_addr  in  ADDR_W  line-aligned base address of the victim
- victim_rdata  in  32  line-array word at vic_idx, combinational, same cycle
- vic_idx  out  OFF_W  victim word index being read
- aw_valid / aw_ready  out/in  1  write-address handshake
- aw_addr  out  ADDR_W  write-burst address; equals victim_addr
- w_valid / w_ready  out/in  1  write-data handshake
- w_data  out  32  write beat; equals victim_rdata
- w_last  out  1  final write beat
- b_valid / b_ready  in/out  1  write response
- ar_valid / ar_ready  out/in  1  read-address handshake
- ar_addr  out  ADDR_W  {miss_addr[ADDR_W-1:2], 2'b00}; wrap burst
- r_valid / r_ready  in/out  1  read-data handshake
- r_data  in  32  read beat
- r_last  in  1  final read beat
- fill_we  out  1  write fill_data into line word fill_idx
- fill_idx  out  OFF_W  refill word index
- fill_data  out  32  equals r_data
- crit_valid  out  1  one-cycle pulse when the critical word arrives
- crit_data  out  32  critical word; valid with crit_valid
- done  out  1  one-cycle pulse; line refilled; tag update with valid=1, dirty=0
- busy  out  1  state != IDLE
- proto_err  out  1  sticky r_last/beat-count mismatch flag; cleared only by reset

## Operation
- States: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE.
- IDLE, miss_req=1:
  - Latch miss_addr, victim_addr and crit = miss_addr[OFF_W+1:2].
  - Next state is WB_AW if victim_dirty, else RD_AR.
- WB_AW: aw_valid=1 until aw_ready, then go to WB_W with the beat counter cleared.
- WB_W:
  - vic_idx = beat counter; w_valid=1.
  - w_last=1 when counter == LINE_WORDS-1.
  - On handshake the counter increments. On the last beat go to WB_B.
- WB_B: b_ready=1; on b_valid go to RD_AR. The refill is never issued before the writeback response.
- RD_AR: ar_valid=1 until ar_ready, then go to RD_R with the beat counter cleared.
- RD_R:
  - r_ready=1. Each beat: fill_we=r_valid, fill_idx = (crit + counter) mod LINE_WORDS, i.e. OFF_W-bit wrap.
  - Beat 0: crit_valid=1, crit_data=r_data.
  - Beat LINE_WORDS-1: go to DONE.
  - Mismatch: if r_last disagrees with (counter == LINE_WORDS-1) on any beat, set proto_err. The count still governs completion; extra beats after DONE are not accepted (r_ready=0).
- DONE: done=1 for one cycle, then IDLE. miss_req is ignored in DONE and for all non-IDLE states.
- valid/address outputs stay stable until their handshake completes, whatever the ready state.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, proto_err 0. All valid/ready/pulse outputs are 0. Address/data outputs are 0.
- Reset mid-burst aborts immediately. Any partial fill is discarded by the cache, because done never pulsed.
- IDLE→WB_AW/RD_AR takes 1 cycle after miss_req is sampled. aw_valid/ar_valid assert in the cycle after acceptance.
- w_data is combinational from victim_rdata: zero-latency line-array read is required.
- Zero-wait memory, clean miss: miss_req at cycle 0; ar handshake at 1; beats at 2..LINE_WORDS+1; done at LINE_WORDS+2. crit_valid is in the same cycle as beat 0.
- Dirty miss adds the write phases: 1 (AW) + LINE_WORDS (W) + 1 (B) cycles minimum.
- fill_we, crit_valid and fill_* are combinational from r_valid in RD_R. done is registered.

## Test plan
- Clean miss: LINE_WORDS=8, miss_addr=0x1014, zero-wait → ar_addr=0x1014, fill_idx 5,6,7,0..4, crit_data = first beat, done on cycle 10, proto_err=0.
- Dirty miss: victim_addr=0x2000, random w_ready stalls → 8 W beats, w_data = words 0..7, w_last only on beat 8; AR is held off until b_valid.
- Random valid/ready backpressure on all channels, LINE_WORDS=4 and 16 → aw/ar addresses stable while pending, every fill word correct, exactly one crit_valid and one done per miss.
- r_last asserted on beat 3 of 8 → proto_err=1 and sticky; refill still completes after 8 beats.
- resetn pulled low during WB_W beat 4 → all outputs 0 asynchronously; next miss runs cleanly.
- miss_req held high through a whole miss → exactly one transaction; the second starts only after returning to IDLE.
